// File: rtl/raifes_dm_ctrl.sv
// Debug-module controller: DMI register file, resume handshake and program-buffer exec sequencer.
// Define RAIFES_DM_AUTOEXEC_EN to implement abstractauto (0x18) with autoexecprogbuf0.
module raifes_dm_ctrl #(
  parameter int unsigned EXEC_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_dmi_req_valid,
  output logic        o_dmi_req_ready,
  input  logic [6:0]  i_dmi_addr,
  input  logic [1:0]  i_dmi_op,
  input  logic [31:0] i_dmi_wdata,
  output logic        o_dmi_resp_valid,
  input  logic        i_dmi_resp_ready,
  output logic [31:0] o_dmi_rdata,
  output logic [1:0]  o_dmi_resp_op,
  output logic        o_haltreq,
  output logic        o_ndmreset,
  output logic        o_resume_req,
  output logic        o_postexec_req,
  output logic [31:0] o_progbuf0,
  output logic [31:0] o_progbuf1,
  input  logic        i_halted,
  input  logic        i_resume_ack
);

  localparam logic [6:0] ADDR_DMCONTROL   = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS    = 7'h11;
  localparam logic [6:0] ADDR_ABSTRACTCS  = 7'h16;
  localparam logic [6:0] ADDR_COMMAND     = 7'h17;
  localparam logic [6:0] ADDR_ABSTRACTAUTO = 7'h18;
  localparam logic [6:0] ADDR_PROGBUF0    = 7'h20;
  localparam logic [6:0] ADDR_PROGBUF1    = 7'h21;

  typedef enum logic {R_IDLE, R_REQ} rstate_t;
  typedef enum logic {E_IDLE, E_BUSY} estate_t;

  logic        r_resp_valid;
  logic [31:0] r_rdata;

  logic        r_dmactive;
  logic        r_haltreq;
  logic        r_ndmreset;
  logic        r_resumeack;
  logic [2:0]  r_cmderr;
  logic [31:0] r_progbuf0;
  logic [31:0] r_progbuf1;
  rstate_t     r_rstate;
  logic        r_resume_req;
  estate_t     r_estate;
  logic [7:0]  r_cnt;
  logic        r_postexec_req;
`ifdef RAIFES_DM_AUTOEXEC_EN
  logic        r_autoexec;
  logic        r_last_vld;
`endif

  logic        w_fire;
  logic        w_wr;
  logic        w_rd;
  logic        w_busy;
  logic        w_dm_clear;
  logic        w_wr_cmd;
  logic        w_auto_trig;
  logic        w_cmd_try;
  logic [7:0]  w_cmd_type;
  logic        w_cmd_transfer;
  logic        w_cmd_postexec;
  logic        w_cmd_launch;
  logic        w_cmd_err_set;
  logic [2:0]  w_cmd_err;
  logic [31:0] w_rdata_mux;

  always_comb begin
    w_fire     = i_dmi_req_valid & ~r_resp_valid;
    w_wr       = w_fire & (i_dmi_op == 2'd2);
    w_rd       = w_fire & (i_dmi_op == 2'd1);
    w_busy     = (r_estate == E_BUSY);
    w_dm_clear = w_wr & (i_dmi_addr == ADDR_DMCONTROL) & ~i_dmi_wdata[0];
    w_wr_cmd   = w_wr & r_dmactive & (i_dmi_addr == ADDR_COMMAND);
`ifdef RAIFES_DM_AUTOEXEC_EN
    w_auto_trig = r_dmactive & r_autoexec & ~w_busy & r_last_vld & (w_wr | w_rd) &
                  (i_dmi_addr == ADDR_PROGBUF0);
`else
    w_auto_trig = 1'b0;
`endif
    w_cmd_try = w_wr_cmd | w_auto_trig;
    // Autoexec replays the only kind of command ever stored: a plain postexec.
    if (w_wr_cmd) begin
      w_cmd_type     = i_dmi_wdata[31:24];
      w_cmd_transfer = i_dmi_wdata[17];
      w_cmd_postexec = i_dmi_wdata[18];
    end else begin
      w_cmd_type     = 8'd0;
      w_cmd_transfer = 1'b0;
      w_cmd_postexec = 1'b1;
    end
  end

  always_comb begin
    w_cmd_launch  = 1'b0;
    w_cmd_err_set = 1'b0;
    w_cmd_err     = 3'd0;
    if (w_cmd_try && (r_cmderr == 3'd0)) begin
      if (w_busy) begin
        w_cmd_err_set = 1'b1;
        w_cmd_err     = 3'd1;
      end else if ((w_cmd_type != 8'd0) || w_cmd_transfer) begin
        w_cmd_err_set = 1'b1;
        w_cmd_err     = 3'd2;
      end else if (w_cmd_postexec && !i_halted) begin
        w_cmd_err_set = 1'b1;
        w_cmd_err     = 3'd4;
      end else if (w_cmd_postexec) begin
        w_cmd_launch = 1'b1;
      end
    end
  end

  always_comb begin
    w_rdata_mux = 32'd0;
    case (i_dmi_addr)
      ADDR_DMCONTROL:  w_rdata_mux = {r_haltreq, 1'b0, 28'd0, r_ndmreset, r_dmactive};
      ADDR_DMSTATUS:   w_rdata_mux = {14'd0, {2{r_resumeack}}, 4'd0, {2{~i_halted}},
                                      {2{i_halted}}, 1'b1, 3'd0, 4'd2};
      ADDR_ABSTRACTCS: w_rdata_mux = {3'd0, 5'd2, 11'd0, w_busy, 1'b0, r_cmderr, 8'd0};
`ifdef RAIFES_DM_AUTOEXEC_EN
      ADDR_ABSTRACTAUTO: w_rdata_mux = {15'd0, r_autoexec, 16'd0};
`endif
      ADDR_PROGBUF0:   w_rdata_mux = r_progbuf0;
      ADDR_PROGBUF1:   w_rdata_mux = r_progbuf1;
      default:         w_rdata_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'd0;
    end else if (w_fire) begin
      r_resp_valid <= 1'b1;
      r_rdata      <= w_rd ? w_rdata_mux : 32'd0;
    end else if (i_dmi_resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  // Clearing dmactive is a soft reset of everything but the DMI response path.
  always_ff @(posedge clk) begin
    if (reset || w_dm_clear) begin
      r_dmactive     <= 1'b0;
      r_haltreq      <= 1'b0;
      r_ndmreset     <= 1'b0;
      r_resumeack    <= 1'b0;
      r_cmderr       <= 3'd0;
      r_progbuf0     <= 32'd0;
      r_progbuf1     <= 32'd0;
      r_rstate       <= R_IDLE;
      r_resume_req   <= 1'b0;
      r_estate       <= E_IDLE;
      r_cnt          <= 8'd0;
      r_postexec_req <= 1'b0;
`ifdef RAIFES_DM_AUTOEXEC_EN
      r_autoexec     <= 1'b0;
      r_last_vld     <= 1'b0;
`endif
    end else begin
      r_postexec_req <= 1'b0;
      if (!r_dmactive) begin
        if (w_wr && (i_dmi_addr == ADDR_DMCONTROL)) r_dmactive <= i_dmi_wdata[0];
      end else begin
        case (r_rstate)
          R_REQ: begin
            if (!r_resume_req) begin
              if (!i_resume_ack) r_resume_req <= 1'b1;
            end else if (i_resume_ack) begin
              r_resume_req <= 1'b0;
              r_resumeack  <= 1'b1;
              r_rstate     <= R_IDLE;
            end
          end
          default: ;
        endcase

        case (r_estate)
          E_BUSY: begin
            if (r_cnt <= 8'd1) begin
              r_estate <= E_IDLE;
              r_cnt    <= 8'd0;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          default: ;
        endcase

        if (w_cmd_launch) begin
          r_estate       <= E_BUSY;
          r_cnt          <= 8'(EXEC_CYCLES);
          r_postexec_req <= 1'b1;
`ifdef RAIFES_DM_AUTOEXEC_EN
          r_last_vld     <= 1'b1;
`endif
        end
        if (w_cmd_err_set) r_cmderr <= w_cmd_err;

        if (w_wr) begin
          case (i_dmi_addr)
            ADDR_DMCONTROL: begin
              r_haltreq  <= i_dmi_wdata[31];
              r_ndmreset <= i_dmi_wdata[1];
              // haltreq in the same access suppresses resumereq
              if (i_dmi_wdata[30] && !i_dmi_wdata[31]) begin
                if (w_busy) begin
                  r_cmderr <= 3'd1;
                end else if (!i_halted) begin
                  r_cmderr <= 3'd4;
                end else begin
                  r_resumeack  <= 1'b0;
                  r_rstate     <= R_REQ;
                  r_resume_req <= ~i_resume_ack;
                end
              end
            end
            ADDR_ABSTRACTCS: r_cmderr <= r_cmderr & ~i_dmi_wdata[10:8];
`ifdef RAIFES_DM_AUTOEXEC_EN
            ADDR_ABSTRACTAUTO: r_autoexec <= i_dmi_wdata[16];
`endif
            ADDR_PROGBUF0: begin
              if (w_busy) r_cmderr <= 3'd1;
              else        r_progbuf0 <= i_dmi_wdata;
            end
            ADDR_PROGBUF1: begin
              if (w_busy) r_cmderr <= 3'd1;
              else        r_progbuf1 <= i_dmi_wdata;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign o_dmi_req_ready  = ~r_resp_valid;
  assign o_dmi_resp_valid = r_resp_valid;
  assign o_dmi_rdata      = r_rdata;
  assign o_dmi_resp_op    = 2'b00;
  assign o_haltreq        = r_haltreq;
  assign o_ndmreset       = r_ndmreset;
  assign o_resume_req     = r_resume_req;
  assign o_postexec_req   = r_postexec_req;
  assign o_progbuf0       = r_progbuf0;
  assign o_progbuf1       = r_progbuf1;

endmodule

// File: tb/tb_raifes_dm_ctrl.sv
// Scoreboard bench for raifes_dm_ctrl: DMI responses are checked against a queue of expectations.
module tb_raifes_dm_ctrl;

  localparam int unsigned EXEC = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_dmi_req_valid;
  logic        o_dmi_req_ready;
  logic [6:0]  i_dmi_addr;
  logic [1:0]  i_dmi_op;
  logic [31:0] i_dmi_wdata;
  logic        o_dmi_resp_valid;
  logic        i_dmi_resp_ready;
  logic [31:0] o_dmi_rdata;
  logic [1:0]  o_dmi_resp_op;
  logic        o_haltreq;
  logic        o_ndmreset;
  logic        o_resume_req;
  logic        o_postexec_req;
  logic [31:0] o_progbuf0;
  logic [31:0] o_progbuf1;
  logic        i_halted;
  logic        i_resume_ack;

  raifes_dm_ctrl #(.EXEC_CYCLES(EXEC)) u_dut (
    .clk              (clk),
    .reset            (reset),
    .i_dmi_req_valid  (i_dmi_req_valid),
    .o_dmi_req_ready  (o_dmi_req_ready),
    .i_dmi_addr       (i_dmi_addr),
    .i_dmi_op         (i_dmi_op),
    .i_dmi_wdata      (i_dmi_wdata),
    .o_dmi_resp_valid (o_dmi_resp_valid),
    .i_dmi_resp_ready (i_dmi_resp_ready),
    .o_dmi_rdata      (o_dmi_rdata),
    .o_dmi_resp_op    (o_dmi_resp_op),
    .o_haltreq        (o_haltreq),
    .o_ndmreset       (o_ndmreset),
    .o_resume_req     (o_resume_req),
    .o_postexec_req   (o_postexec_req),
    .o_progbuf0       (o_progbuf0),
    .o_progbuf1       (o_progbuf1),
    .i_halted         (i_halted),
    .i_resume_ack     (i_resume_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_pulse = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (o_postexec_req) n_pulse <= n_pulse + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // A response is popped exactly once: in the cycle it is accepted.
  always @(negedge clk) begin
    if (o_dmi_resp_valid && i_dmi_resp_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("resp_without_request", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq(e.tag, o_dmi_rdata, e.exp);
        check_eq({e.tag, "_op"}, 32'(o_dmi_resp_op), 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic dmi(input string tag, input logic [1:0] op, input logic [6:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp);
    int n;
    exp_t e;
    n = 0;
    while (!o_dmi_req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_dmi_req_ready) check_eq({tag, "_ready_timeout"}, 32'(o_dmi_req_ready), 32'd1);
    e.tag = tag;
    e.exp = exp;
    exp_q.push_back(e);
    i_dmi_req_valid = 1'b1;
    i_dmi_op        = op;
    i_dmi_addr      = addr;
    i_dmi_wdata     = wd;
    @(negedge clk);
    i_dmi_req_valid = 1'b0;
    i_dmi_op        = 2'd0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
    check_eq("poll_cycle", 32'(cyc), 32'(target));
  endtask

  localparam logic [1:0] RD = 2'd1;
  localparam logic [1:0] WR = 2'd2;

  initial begin
    int pc;
    int p0;
    reset            = 1'b1;
    i_dmi_req_valid  = 1'b0;
    i_dmi_addr       = 7'd0;
    i_dmi_op         = 2'd0;
    i_dmi_wdata      = 32'd0;
    i_dmi_resp_ready = 1'b1;
    i_halted         = 1'b0;
    i_resume_ack     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check_eq("rst_req_ready", 32'(o_dmi_req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(o_dmi_resp_valid), 32'd0);
    check_eq("rst_rdata", o_dmi_rdata, 32'd0);
    check_eq("rst_ctrl", {28'd0, o_haltreq, o_ndmreset, o_resume_req, o_postexec_req}, 32'd0);
    check_eq("rst_pb0", o_progbuf0, 32'd0);
    check_eq("rst_pb1", o_progbuf1, 32'd0);

    // Inactive DM ignores register writes
    dmi("inact_wr_pb0", WR, 7'h20, 32'h0000_1234, 32'd0);
    dmi("inact_rd_pb0", RD, 7'h20, 32'd0, 32'd0);
    dmi("act_wr", WR, 7'h10, 32'h1, 32'd0);
    i_halted = 1'b1;
    dmi("dmstatus_halted", RD, 7'h11, 32'd0, 32'h0000_0382);
    dmi("abstractcs_rst", RD, 7'h16, 32'd0, 32'h0200_0000);
    dmi("nop", 2'd0, 7'h10, 32'd0, 32'd0);
    dmi("unmapped", RD, 7'h05, 32'd0, 32'd0);

    dmi("wr_pb0", WR, 7'h20, 32'h0010_0073, 32'd0);
    check_eq("pb0_out", o_progbuf0, 32'h0010_0073);
    dmi("wr_pb1", WR, 7'h21, 32'hDEAD_BEEF, 32'd0);
    dmi("rd_pb1", RD, 7'h21, 32'd0, 32'hDEAD_BEEF);

    // Postexec: pulse at N+1, busy for EXEC cycles
    p0 = n_pulse;
    dmi("cmd1", WR, 7'h17, 32'h0004_0000, 32'd0);
    check_eq("postexec_n1", 32'(o_postexec_req), 32'd1);
    pc = cyc;
    @(negedge clk);
    check_eq("postexec_n2", 32'(o_postexec_req), 32'd0);
    dmi("cmd_busy", WR, 7'h17, 32'h0004_0000, 32'd0);
    dmi("cs_err1", RD, 7'h16, 32'd0, 32'h0200_1100);
    dmi("cs_clr", WR, 7'h16, 32'h700, 32'd0);
    dmi("cs_cleared", RD, 7'h16, 32'd0, 32'h0200_1000);
    dmi("pb0_busy_wr", WR, 7'h20, 32'h5555_5555, 32'd0);
    check_eq("pb0_hold", o_progbuf0, 32'h0010_0073);
    dmi("cs_err_pb", RD, 7'h16, 32'd0, 32'h0200_1100);
    dmi("cs_clr2", WR, 7'h16, 32'h100, 32'd0);
    check_eq("one_pulse", 32'(n_pulse), 32'(p0 + 1));
    wait_until(pc + EXEC - 1);
    dmi("busy_last", RD, 7'h16, 32'd0, 32'h0200_1000);
    dmi("busy_done", RD, 7'h16, 32'd0, 32'h0200_0000);

    // Command error classes
    dmi("cmd_type", WR, 7'h17, 32'h0104_0000, 32'd0);
    dmi("cs_err2", RD, 7'h16, 32'd0, 32'h0200_0200);
    dmi("cs_clr3", WR, 7'h16, 32'h200, 32'd0);
    i_halted = 1'b0;
    p0 = n_pulse;
    dmi("cmd_nohalt", WR, 7'h17, 32'h0004_0000, 32'd0);
    dmi("cs_err4", RD, 7'h16, 32'd0, 32'h0200_0400);
    dmi("cs_clr4", WR, 7'h16, 32'h700, 32'd0);
    check_eq("no_pulse_err", 32'(n_pulse), 32'(p0));

    // Resume handshake
    i_halted = 1'b1;
    dmi("resume", WR, 7'h10, 32'h4000_0001, 32'd0);
    check_eq("resume_req_on", 32'(o_resume_req), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("resume_req_hold", 32'(o_resume_req), 32'd1);
    i_resume_ack = 1'b1;
    @(negedge clk);
    check_eq("resume_req_off", 32'(o_resume_req), 32'd0);
    dmi("dmstatus_ack", RD, 7'h11, 32'd0, 32'h0003_0382);
    i_resume_ack = 1'b0;
    i_halted = 1'b0;
    dmi("dmstatus_run", RD, 7'h11, 32'd0, 32'h0003_0C82);
    dmi("resume_nohalt", WR, 7'h10, 32'h4000_0001, 32'd0);
    check_eq("resume_req_err", 32'(o_resume_req), 32'd0);
    dmi("cs_err4_res", RD, 7'h16, 32'd0, 32'h0200_0400);
    dmi("cs_clr5", WR, 7'h16, 32'h400, 32'd0);
    i_halted = 1'b1;
    dmi("halt_and_resume", WR, 7'h10, 32'hC000_0001, 32'd0);
    check_eq("haltreq_wins", {30'd0, o_haltreq, o_resume_req}, 32'd2);
    dmi("rd_ctrl_halt", RD, 7'h10, 32'd0, 32'h8000_0001);
    dmi("ack_sticky", RD, 7'h11, 32'd0, 32'h0003_0382);
    dmi("ndmreset", WR, 7'h10, 32'h3, 32'd0);
    check_eq("ndmreset_out", {30'd0, o_haltreq, o_ndmreset}, 32'd1);
    dmi("rd_ctrl_ndm", RD, 7'h10, 32'd0, 32'h3);

    // dmactive clear mid-exec
    dmi("pb1_wr2", WR, 7'h21, 32'h1111_2222, 32'd0);
    dmi("cmd2", WR, 7'h17, 32'h0004_0000, 32'd0);
    dmi("cmd2_busy", WR, 7'h17, 32'h0004_0000, 32'd0);
    dmi("deact", WR, 7'h10, 32'h0, 32'd0);
    check_eq("deact_pb0", o_progbuf0, 32'd0);
    check_eq("deact_pb1", o_progbuf1, 32'd0);
    check_eq("deact_ndm", 32'(o_ndmreset), 32'd0);
    dmi("deact_cs", RD, 7'h16, 32'd0, 32'h0200_0000);
    dmi("deact_wr_pb0", WR, 7'h20, 32'h0000_0ABC, 32'd0);
    dmi("deact_rd_pb0", RD, 7'h20, 32'd0, 32'd0);
    dmi("deact_rd_ctrl", RD, 7'h10, 32'd0, 32'd0);

    // Busy must be clear exactly EXEC cycles after the pulse
    dmi("react", WR, 7'h10, 32'h1, 32'd0);
    dmi("cmd3", WR, 7'h17, 32'h0004_0000, 32'd0);
    pc = cyc;
    wait_until(pc + EXEC);
    dmi("busy_edge", RD, 7'h16, 32'd0, 32'h0200_0000);

    // Back-pressure stalls requests, not the exec FSM
    dmi("cmd4", WR, 7'h17, 32'h0004_0000, 32'd0);
    @(negedge clk);
    i_dmi_resp_ready = 1'b0;
    dmi("bp_rd", RD, 7'h16, 32'd0, 32'h0200_1000);
    repeat (70) @(negedge clk);
    check_eq("bp_valid", {30'd0, o_dmi_resp_valid, o_dmi_req_ready}, 32'd2);
    @(posedge clk);
    #1 i_dmi_resp_ready = 1'b1;
    @(negedge clk);
    dmi("bp_after", RD, 7'h16, 32'd0, 32'h0200_0000);

`ifdef RAIFES_DM_AUTOEXEC_EN
    dmi("auto_wr", WR, 7'h18, 32'h0001_0000, 32'd0);
    dmi("auto_rd", RD, 7'h18, 32'd0, 32'h0001_0000);
    p0 = n_pulse;
    dmi("auto_pb0", WR, 7'h20, 32'h0010_0073, 32'd0);
    check_eq("auto_pulse_n1", 32'(o_postexec_req), 32'd1);
    check_eq("auto_pb0_out", o_progbuf0, 32'h0010_0073);
    repeat (EXEC + 4) @(negedge clk);
    check_eq("auto_one_pulse", 32'(n_pulse), 32'(p0 + 1));
`else
    dmi("auto_wr", WR, 7'h18, 32'h0001_0000, 32'd0);
    dmi("auto_rd", RD, 7'h18, 32'd0, 32'd0);
    dmi("auto_pb0", WR, 7'h20, 32'h0010_0073, 32'd0);
    check_eq("auto_no_pulse", 32'(o_postexec_req), 32'd0);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/raifes_dm_ctrl.md
# raifes_dm_ctrl

Debug-module controller that terminates the DMI bus from the JTAG DTM and drives the debug ROM/program-buffer block. It holds the debugger-visible registers (dmcontrol, dmstatus, abstractcs, command, progbuf0/1) and runs the resume handshake and the program-buffer execution sequencer. It is the single source of `progbuf0/1`, `resume_req` and `postexec_req`, and it consumes `halted` and `resume_ack` from the ROM block.

## Interface
- `EXEC_CYCLES`, default 64: cycles the controller stays busy after a `postexec_req` pulse (range 4..255).
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `dmi_req_valid`  in  1  DMI request valid
- `dmi_req_ready`  out  1  DMI request accepted
- `dmi_addr`  in  7  DM register address
- `dmi_op`  in  2  0 = nop, 1 = read, 2 = write
- `dmi_wdata`  in  32  write data
- `dmi_resp_valid`  out  1  response valid
- `dmi_resp_ready`  in  1  response consumed
- `dmi_rdata`  out  32  read data; 0 for nop, write, or unmapped address
- `dmi_resp_op`  out  2  always 0 (success)
- `haltreq`  out  1  halt request to core, level
- `ndmreset`  out  1  system reset request, level
- `resume_req`  out  1  to ROM, level
- `postexec_req`  out  1  to ROM, one-cycle pulse
- `progbuf0`, `progbuf1`  out  32  program-buffer words to ROM
- `halted`  in  1  from ROM
- `resume_ack`  in  1  from ROM

## Operation
- **DMI handshake**
  - One transaction in flight; `dmi_req_ready = ~dmi_resp_valid`.
  - A request is accepted on `valid & ready`. Its response is registered and valid the next cycle, then held until `dmi_resp_ready`.
- **Address map**
  - 0x10 dmcontrol: [31] haltreq, [30] resumereq (W1, reads 0), [1] ndmreset, [0] dmactive.
  - 0x11 dmstatus, read-only: [17:16] resumeack (sticky), [11:10] ~halted, [9:8] halted, [7] = 1, [3:0] = 2.
  - 0x16 abstractcs: [28:24] = 2, [12] busy, [10:8] cmderr (write 1 to clear per bit), datacount = 0.
  - 0x17 command: write-only, reads 0.
  - 0x20 / 0x21: progbuf0 / progbuf1, read/write.
- **dmactive**
  - While dmactive = 0, every register except dmactive holds its reset value and writes to them are ignored.
  - A write that clears dmactive resets that state on the next cycle.
- **Resume FSM (R_IDLE, R_REQ)**
  - A resumereq write while `halted = 1` clears sticky resumeack and enters R_REQ.
  - In R_REQ, `resume_req` is asserted only once `resume_ack` has been sampled 0. It is then held until `resume_ack = 1`, at which point resumeack is set, the FSM returns to R_IDLE and `resume_req` drops.
  - A resumereq write while not halted sets cmderr = 4 and does nothing else.
  - If haltreq and resumereq are written in the same access, haltreq wins and resumereq is ignored.
- **Exec FSM (E_IDLE, E_BUSY)**
  - A command write is evaluated as follows:
    - If cmderr ≠ 0: ignored.
    - Else if busy: cmderr = 1.
    - Else if cmdtype[31:24] ≠ 0 or transfer[17] = 1: cmderr = 2.
    - Else if postexec[18] = 1 and `halted = 0`: cmderr = 4.
    - Else if postexec = 1: pulse `postexec_req` for one cycle, set busy, load the counter with `EXEC_CYCLES`, enter E_BUSY.
    - Else (postexec = 0): no-op success.
  - E_BUSY decrements the counter each cycle and returns to E_IDLE (busy = 0) at 0.
  - Writes to progbuf0/1 while busy set cmderr = 1 and do not change the progbuf contents.
  - A resumereq write while busy sets cmderr = 1.

## Timing
- **Reset values:** `dmi_req_ready` = 1; `dmi_resp_valid`, `dmi_rdata`, `haltreq`, `ndmreset`, `resume_req`, `postexec_req` = 0; `progbuf0/1` = 0; busy = 0; cmderr = 0; both FSMs idle.
- **Latency:** request accepted at cycle N gives response valid at N+1. A register write is visible on outputs at N+1.
- **postexec_req:** asserted exactly at N+1 after the command write; busy is readable as 1 from N+1.
- **Busy duration:** busy falls `EXEC_CYCLES` cycles after the pulse.
- **Reset mid-operation:** reset or dmactive clear aborts R_REQ and E_BUSY immediately; outputs go to reset values the next cycle.
- **Back-pressure:** response back-pressure stalls new requests only; both FSMs keep running.

## Configuration
- `RAIFES_DM_AUTOEXEC_EN` defined:
  - Register 0x18 abstractauto is implemented, with bit [16] autoexecprogbuf0 (read/write).
  - When bit [16] is set and not busy, any read or write of progbuf0 re-executes the last accepted postexec command, applying the same cmderr rules.
  - A progbuf0 write lands before the triggered execution.
- `RAIFES_DM_AUTOEXEC_EN` undefined: 0x18 reads 0 and writes to it are ignored.

## Test plan
- Write 0x10 = 0x1, then read 0x11 with `halted = 1` -> rdata = 0x0000_0382.
- Write progbuf0 = 0x0010_0073, `halted = 1`, write 0x17 = 0x0004_0000 -> one-cycle `postexec_req` at N+1; abstractcs.busy = 1 for 64 cycles, then 0.
- Write the command again while busy -> cmderr = 1 and no pulse; write 0x16 = 0x700 -> cmderr = 0.
- `halted = 1`, `resume_ack` held 0, write 0x10 = 0x4000_0001 -> `resume_req` = 1; raise `resume_ack` -> `resume_req` = 0 next cycle and dmstatus[17:16] = 3.
- Write 0x10 = 0x0 mid-exec -> busy = 0, cmderr = 0, progbuf = 0, and writes to 0x20 are ignored until dmactive is set again.
- With `RAIFES_DM_AUTOEXEC_EN`: set 0x18 = 0x1_0000 after one successful postexec command, then write 0x20 -> `postexec_req` pulses once.
